// File: rtl/dma_pcis_pkt_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_pcis_pkt_serializer                                                    |
// | Splits unified PKT_W write packets into WORD_W words. Define               |
// | DMA_PCIS_SER_DBUF_EN to add a next-packet buffer for bubble-free streaming.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dma_pcis_pkt_serializer #(
  parameter int PKT_W     = 512,
  parameter int WORD_W    = 64,
  parameter bit MSW_FIRST = 1'b0,
  localparam int NUM_WORDS = PKT_W / WORD_W,
  localparam int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PKT_W-1:0]  packet_in,
  input  logic              packet_in_valid,
  output logic              packet_in_grant,
  output logic [WORD_W-1:0] word_out,
  output logic [IDX_W-1:0]  word_out_idx,
  output logic              word_out_valid,
  output logic              word_out_last,
  input  logic              word_out_grant,
  output logic              busy
);

  if (PKT_W % WORD_W != 0) begin : g_bad_width
    $error("PKT_W must be a multiple of WORD_W");
  end

  localparam logic [0:0]       ST_EMPTY  = 1'b0;
  localparam logic [0:0]       ST_SERIAL = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             grant_en_q;
  logic [PKT_W-1:0] act_data_q;
  logic             act_load;
  logic             nxt_full_q;
  logic [IDX_W-1:0] sel;
  logic             in_xfer, out_xfer, last_xfer;

  assign in_xfer   = packet_in_valid && packet_in_grant;
  assign out_xfer  = word_out_valid && word_out_grant;
  assign last_xfer = out_xfer && (idx_q == LAST_IDX);

  if (MSW_FIRST) begin : g_msw_first
    assign sel = LAST_IDX - idx_q;
  end else begin : g_lsw_first
    assign sel = idx_q;
  end

`ifdef DMA_PCIS_SER_DBUF_EN
  logic             nxt_full_d;
  logic             act_from_nxt;
  logic [PKT_W-1:0] nxt_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nxt_full_q <= 1'b0;
    else        nxt_full_q <= nxt_full_d;
  end

  // Capturing on every accept is harmless: NXT is only read when nxt_full_q is set.
  always_ff @(posedge clk) begin
    if (in_xfer) nxt_data_q <= packet_in;
  end

  always_ff @(posedge clk) begin
    if (act_from_nxt)  act_data_q <= nxt_data_q;
    else if (act_load) act_data_q <= packet_in;
  end
`else
  assign nxt_full_q = 1'b0;

  always_ff @(posedge clk) begin
    if (act_load) act_data_q <= packet_in;
  end
`endif

  // grant_en_q keeps the input closed until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      idx_q      <= '0;
      grant_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      grant_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    act_load = 1'b0;
`ifdef DMA_PCIS_SER_DBUF_EN
    nxt_full_d   = nxt_full_q;
    act_from_nxt = 1'b0;
`endif
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d  = ST_SERIAL;
          idx_d    = '0;
          act_load = 1'b1;
        end
      end
      default: begin
        if (out_xfer && (idx_q != LAST_IDX)) begin
          idx_d = idx_q + 1'b1;
        end else if (last_xfer) begin
`ifdef DMA_PCIS_SER_DBUF_EN
          if (nxt_full_q) begin
            idx_d        = '0;
            act_from_nxt = 1'b1;
            nxt_full_d   = 1'b0;
          end else if (in_xfer) begin
            idx_d    = '0;
            act_load = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
`else
          state_d = ST_EMPTY;
`endif
        end
`ifdef DMA_PCIS_SER_DBUF_EN
        if (in_xfer && !last_xfer) nxt_full_d = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    word_out_valid = (state_q == ST_SERIAL);
    word_out_last  = word_out_valid && (idx_q == LAST_IDX);
    word_out       = word_out_valid ? act_data_q[sel*WORD_W +: WORD_W] : '0;
    word_out_idx   = idx_q;
    busy           = word_out_valid || nxt_full_q;
`ifdef DMA_PCIS_SER_DBUF_EN
    packet_in_grant = grant_en_q && !nxt_full_q;
`else
    packet_in_grant = grant_en_q && (state_q == ST_EMPTY);
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_pcis_pkt_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dma_pcis_pkt_serializer                                                 |
// | Scoreboard bench: LSW-first and MSW-first instances driven in lockstep.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dma_pcis_pkt_serializer;

  localparam int PKT_W  = 512;
  localparam int WORD_W = 64;
  localparam int NW     = 8;
`ifdef DMA_PCIS_SER_DBUF_EN
  localparam int EXP_SPAN = 16;
`else
  localparam int EXP_SPAN = 17;
`endif

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [2:0]        idx;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PKT_W-1:0]  packet_in;
  logic              packet_in_valid;
  logic              word_out_grant;

  logic              grant_l, v_l, last_l, busy_l;
  logic [WORD_W-1:0] wo_l;
  logic [2:0]        idx_l;
  logic              grant_m, v_m, last_m, busy_m;
  logic [WORD_W-1:0] wo_m;
  logic [2:0]        idx_m;

  exp_t        q_lsw[$];
  exp_t        q_msw[$];
  exp_t        e_l, e_m;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [PKT_W-1:0] p;
  bit          found;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dma_pcis_pkt_serializer #(.PKT_W(PKT_W), .WORD_W(WORD_W), .MSW_FIRST(1'b0)) u_dut_lsw (
    .clk(clk), .rst_n(rst_n), .packet_in(packet_in), .packet_in_valid(packet_in_valid),
    .packet_in_grant(grant_l), .word_out(wo_l), .word_out_idx(idx_l),
    .word_out_valid(v_l), .word_out_last(last_l), .word_out_grant(word_out_grant),
    .busy(busy_l)
  );

  dma_pcis_pkt_serializer #(.PKT_W(PKT_W), .WORD_W(WORD_W), .MSW_FIRST(1'b1)) u_dut_msw (
    .clk(clk), .rst_n(rst_n), .packet_in(packet_in), .packet_in_valid(packet_in_valid),
    .packet_in_grant(grant_m), .word_out(wo_m), .word_out_idx(idx_m),
    .word_out_valid(v_m), .word_out_last(last_m), .word_out_grant(word_out_grant),
    .busy(busy_m)
  );

  // Monitor: every word transfer pops one expected entry per instance.
  always @(negedge clk) begin
    if (rst_n && word_out_grant && v_l) begin
      checks++;
      if (q_lsw.size() == 0) begin
        errors++;
        $display("FAIL lsw_unexpected: got %h idx %0d, required no word", wo_l, idx_l);
      end else begin
        e_l = q_lsw.pop_front();
        if ({wo_l, idx_l, last_l} !== e_l) begin
          errors++;
          $display("FAIL lsw_word: got %h/%0d/%b required %h/%0d/%b",
                   wo_l, idx_l, last_l, e_l.data, e_l.idx, e_l.last);
        end
      end
    end
    if (rst_n && word_out_grant && v_m) begin
      checks++;
      if (q_msw.size() == 0) begin
        errors++;
        $display("FAIL msw_unexpected: got %h idx %0d, required no word", wo_m, idx_m);
      end else begin
        e_m = q_msw.pop_front();
        if ({wo_m, idx_m, last_m} !== e_m) begin
          errors++;
          $display("FAIL msw_word: got %h/%0d/%b required %h/%0d/%b",
                   wo_m, idx_m, last_m, e_m.data, e_m.idx, e_m.last);
        end
      end
    end
  end

  function automatic logic [PKT_W-1:0] mk(input logic [7:0] base);
    logic [PKT_W-1:0] r;
    for (int i = 0; i < PKT_W/8; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [PKT_W-1:0] pk);
    exp_t x;
    for (int k = 0; k < NW; k++) begin
      x.idx  = 3'(k);
      x.last = (k == NW-1);
      x.data = pk[k*WORD_W +: WORD_W];
      q_lsw.push_back(x);
      x.data = pk[(NW-1-k)*WORD_W +: WORD_W];
      q_msw.push_back(x);
    end
  endtask

  task automatic send(input logic [PKT_W-1:0] pk);
    logic g;
    bit   done;
    done = 1'b0;
    packet_in       = pk;
    packet_in_valid = 1'b1;
    for (int t = 0; t < 60 && !done; t++) begin
      g = grant_l;
      tick();
      if (g) done = 1'b1;
    end
    if (done) push_exp(pk);
    else begin
      checks++; errors++;
      $display("FAIL send_timeout: got no grant, required grant within 60 cycles");
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      if (q_lsw.size() == 0 && q_msw.size() == 0 && !busy_l) done = 1'b1;
      else tick();
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy %b pending %0d, required drained", busy_l, q_lsw.size());
    end
  endtask

  task automatic measure_b2b();
    int n, first, lastc;
    n = 0; first = 0; lastc = 0;
    for (int t = 0; t < 200 && n < 16; t++) begin
      @(negedge clk);
      if (v_l && word_out_grant) begin
        if (n == 0) first = cyc;
        n++;
        lastc = cyc;
      end
    end
    chk("b2b_words", 64'(n), 64'd16);
    chk("b2b_span", 64'(lastc - first + 1), 64'(EXP_SPAN));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_word"},  wo_l, 64'd0);
    chk({tag, "_wordm"}, wo_m, 64'd0);
    chk({tag, "_idx"},   64'(idx_l), 64'd0);
    chk({tag, "_valid"}, 64'(v_l), 64'd0);
    chk({tag, "_last"},  64'(last_l), 64'd0);
    chk({tag, "_busy"},  64'({busy_l, busy_m}), 64'd0);
    chk({tag, "_grant"}, 64'({grant_l, grant_m}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    packet_in       = mk(8'h00);
    packet_in_valid = 1'b1;
    word_out_grant  = 1'b1;

    // Reset with valid held high, then release.
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    chk("grant_before_first_edge", 64'(grant_l), 64'd0);
    tick();
    chk("grant_after_first_edge", 64'(grant_l), 64'd1);
    chk("valid_after_first_edge", 64'(v_l), 64'd0);

    // Single packet, bytes 0x00..0x3F, consumer always ready.
    send(mk(8'h00));
    chk("latency_valid", 64'(v_l), 64'd1);
    chk("latency_idx", 64'(idx_l), 64'd0);
    chk("first_word", wo_l, 64'h0706050403020100);
    chk("first_word_msw", wo_m, 64'h3F3E3D3C3B3A3938);
    packet_in_valid = 1'b0;
    wait_idle();

    // Two back-to-back packets.
    fork
      begin
        send(mk(8'h40));
        send(mk(8'h80));
        packet_in_valid = 1'b0;
      end
      measure_b2b();
    join
    wait_idle();

    // Consumer stalls word 3.
    p = mk(8'hC0);
    send(p);
    packet_in_valid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      if (v_l && idx_l == 3'd3) found = 1'b1;
      else tick();
    end
    chk("stall_reach_idx3", 64'(found), 64'd1);
    word_out_grant = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_word", wo_l, p[3*WORD_W +: WORD_W]);
      chk("stall_idx", 64'(idx_l), 64'd3);
    end
    word_out_grant = 1'b1;
    wait_idle();

    // Reset pulse after word 4 has transferred.
    send(mk(8'h11));
    packet_in_valid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      if (v_l && idx_l == 3'd5) found = 1'b1;
      else tick();
    end
    chk("midpkt_reach_idx5", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    q_lsw.delete();
    q_msw.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(mk(8'h5A));
    chk("post_reset_idx", 64'(idx_l), 64'd0);
    packet_in_valid = 1'b0;
    wait_idle();

    chk("scoreboard_empty", 64'(q_lsw.size() + q_msw.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
